// File: rtl/mcif_write_cq_pkg.sv
// -----------------------------------------------------------------------------
// mcif_write_cq_pkg
//   Shared definitions for the MCIF write context queue.
//   A context is 3 bits: {len[1:0], require_ack}. Each context is tagged
//   with one of five write DMA client threads.
// -----------------------------------------------------------------------------
package mcif_write_cq_pkg;

  localparam int CQ_THREADS = 5;
  localparam int CQ_PD_W    = 3;
  localparam int CQ_TID_W   = 3;

  // Context field positions
  localparam int CQ_ACK_BIT = 0;
  localparam int CQ_LEN_LSB = 1;
  localparam int CQ_LEN_W   = 2;

  // Write DMA client thread ids
  typedef enum logic [CQ_TID_W-1:0] {
    BDMA = 3'd0,
    SDP  = 3'd1,
    PDP  = 3'd2,
    CDP  = 3'd3,
    RBK  = 3'd4
  } cq_thread_e;

  typedef logic [CQ_PD_W-1:0] cq_pd_t;

  // True for ids that map onto a real thread FIFO
  function automatic logic cq_tid_valid(input logic [CQ_TID_W-1:0] tid);
    return tid < CQ_TID_W'(CQ_THREADS);
  endfunction

endpackage

// File: rtl/mcif_write_cq_fifo.sv
// -----------------------------------------------------------------------------
// mcif_write_cq_fifo
//   Single-thread in-order context FIFO. One instance per write DMA client.
//   Ports:
//     nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//     push, pd_in : write request and context (ignored while full)
//     full        : count == DEPTH, from registered state
//     pop         : read request (ignored while empty)
//     pd_out      : head context, combinational read; 0 while empty
//     empty       : count == 0, from registered state
//   DEPTH must be a power of two, minimum 2, so pointers wrap naturally.
// -----------------------------------------------------------------------------
module mcif_write_cq_fifo
  import mcif_write_cq_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   nvdla_core_clk,
  input  logic   nvdla_core_rstn,
  input  logic   push,
  input  cq_pd_t pd_in,
  output logic   full,
  input  logic   pop,
  output cq_pd_t pd_out,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  cq_pd_t        mem [DEPTH];

  logic push_en;
  logic pop_en;

  // Full blocks a push even when a pop happens in the same cycle, so prdy
  // never depends on the egress side.
  assign push_en = push & ~full;
  assign pop_en  = pop  & ~empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it was
  // written, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge nvdla_core_clk) begin
    if (push_en) mem[wr_ptr] <= pd_in;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Masked while empty so the unreset storage never reaches the outputs.
  assign pd_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mcif_write_cq.sv
// -----------------------------------------------------------------------------
// mcif_write_cq
//   Write context queue for the MCIF write path. Ingress pushes one context
//   per issued AXI write, tagged with a thread id; egress pops the head of the
//   matching thread when that thread's B response arrives.
//   Threads: 0=bdma 1=sdp 2=pdp 3=cdp 4=rbk. Ids 5..7 are accepted and dropped.
//   Ports:
//     nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//     cq_wr_pvld/prdy/thread_id/pd    : push interface
//     cq_rdN_pvld/prdy/pd (N=0..4)    : per-thread head and pop
//     cq_idle                         : all five FIFOs empty
//     cq_err (only with NVDLA_MCIF_WRITE_CQ_ERR_CHK_EN) : sticky protocol error
//   Optional feature macro: NVDLA_MCIF_WRITE_CQ_ERR_CHK_EN
// -----------------------------------------------------------------------------
module mcif_write_cq
  import mcif_write_cq_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                cq_wr_pvld,
  output logic                cq_wr_prdy,
  input  logic [CQ_TID_W-1:0] cq_wr_thread_id,
  input  cq_pd_t              cq_wr_pd,
  output logic                cq_rd0_pvld,
  input  logic                cq_rd0_prdy,
  output cq_pd_t              cq_rd0_pd,
  output logic                cq_rd1_pvld,
  input  logic                cq_rd1_prdy,
  output cq_pd_t              cq_rd1_pd,
  output logic                cq_rd2_pvld,
  input  logic                cq_rd2_prdy,
  output cq_pd_t              cq_rd2_pd,
  output logic                cq_rd3_pvld,
  input  logic                cq_rd3_prdy,
  output cq_pd_t              cq_rd3_pd,
  output logic                cq_rd4_pvld,
  input  logic                cq_rd4_prdy,
  output cq_pd_t              cq_rd4_pd,
  output logic                cq_idle
`ifdef NVDLA_MCIF_WRITE_CQ_ERR_CHK_EN
  ,
  output logic                cq_err
`endif
);

  logic [CQ_THREADS-1:0] push_sel;
  logic [CQ_THREADS-1:0] full;
  logic [CQ_THREADS-1:0] empty;
  logic [CQ_THREADS-1:0] rd_prdy;
  cq_pd_t                rd_pd [CQ_THREADS];

  // Id decode and prdy mux. An out-of-range id matches no thread, so the beat
  // is accepted (prdy stays 1) and written nowhere.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    push_sel   = '0;
    cq_wr_prdy = 1'b1;
    for (int i = 0; i < CQ_THREADS; i++) begin
      if (cq_wr_thread_id == CQ_TID_W'(i)) begin
        cq_wr_prdy  = ~full[i];
        push_sel[i] = cq_wr_pvld;
      end
    end
  end

  assign rd_prdy = {cq_rd4_prdy, cq_rd3_prdy, cq_rd2_prdy, cq_rd1_prdy, cq_rd0_prdy};

  for (genvar g = 0; g < CQ_THREADS; g++) begin : g_thread
    mcif_write_cq_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .push            (push_sel[g]),
      .pd_in           (cq_wr_pd),
      .full            (full[g]),
      .pop             (rd_prdy[g]),
      .pd_out          (rd_pd[g]),
      .empty           (empty[g])
    );
  end

  assign cq_rd0_pvld = ~empty[BDMA];
  assign cq_rd1_pvld = ~empty[SDP];
  assign cq_rd2_pvld = ~empty[PDP];
  assign cq_rd3_pvld = ~empty[CDP];
  assign cq_rd4_pvld = ~empty[RBK];

  assign cq_rd0_pd = rd_pd[BDMA];
  assign cq_rd1_pd = rd_pd[SDP];
  assign cq_rd2_pd = rd_pd[PDP];
  assign cq_rd3_pd = rd_pd[CDP];
  assign cq_rd4_pd = rd_pd[RBK];

  assign cq_idle = &empty;

`ifdef NVDLA_MCIF_WRITE_CQ_ERR_CHK_EN
  // Error events: a B response with no context queued, or a push with an id
  // that names no thread (such a push is always accepted).
  logic err_evt;
  assign err_evt = (|(rd_prdy & empty)) |
                   (cq_wr_pvld & ~cq_tid_valid(cq_wr_thread_id));

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) cq_err <= 1'b0;
    else                  cq_err <= cq_err | err_evt;
  end

`ifdef ASSERT_ON
  a_no_err_evt: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !err_evt)
    else $error("mcif_write_cq: pop on empty thread or push with invalid thread id");
`endif
`endif

endmodule
